// File: rtl/count_step_checker.sv
// count_step_checker: checks counter steps for legal +1/-1/hold, tracks lock, wraps and errors
module count_step_checker #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              en,
  input  logic [WIDTH-1:0]  q,
  input  logic              s,
  input  logic              clr,
  output logic              locked,
  output logic              step_err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
  localparam logic [3:0] LOCK_V = 4'(LOCK_N);
  state_t           state;
  logic [WIDTH-1:0] prev, exp_q;
  logic [3:0]       run, run_inc;
  logic             hold, good, bad, wrap_ev, err_ev;
  always_comb begin
    exp_q   = s ? prev + 1'b1 : prev - 1'b1;
    hold    = q == prev;
    good    = !hold && q == exp_q;
    bad     = !hold && !good;
    run_inc = run + 4'd1;
    wrap_ev = en && state != IDLE && good && (s ? &prev : ~|prev);
    err_ev  = en && state == LOCKED && bad;
  end
  assign locked = state == LOCKED;
  always_ff @(posedge clk) begin
    if (rest) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      step_err   <= 1'b0;
      wrap       <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
    end else begin
      step_err   <= err_ev;
      wrap       <= wrap_ev;
      err_sticky <= clr ? 1'b0 : err_sticky | err_ev;
      err_cnt    <= clr ? '0 : (err_ev && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
      wrap_cnt   <= clr ? '0 : (wrap_ev && !(&wrap_cnt)) ? wrap_cnt + 1'b1 : wrap_cnt;
      if (en) begin
        prev <= q;
        if (state == IDLE) begin
          state <= ACQ;
          run   <= '0;
        end else if (state == ACQ) begin
          if (good) begin
            run <= run_inc;
            if (run_inc == LOCK_V) state <= LOCKED;
          end else if (bad) begin
            run <= '0;
          end
        end else if (bad) begin
          state <= ACQ;
          run   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_count_step_checker.sv
// tb_count_step_checker: randomized and directed checks against a behavioural step model
module tb_count_step_checker;
  logic       clk = 1'b0;
  logic       rest, en, s, clr;
  logic [3:0] q;
  logic       locked, step_err, err_sticky, wrap;
  logic [7:0] err_cnt, wrap_cnt;
  logic       locked_b, step_err_b, err_sticky_b, wrap_b;
  logic [1:0] err_cnt_b;
  logic [7:0] wrap_cnt_b;
  int         n_cmp = 0, n_fail = 0;
  int         m_mode, m_prev, m_run, m_errc, m_errc2, m_wrapc;
  bit         m_serr, m_wrap, m_sticky;
  always #5 clk = ~clk;
  count_step_checker dut (
    .clk(clk), .rest(rest), .en(en), .q(q), .s(s), .clr(clr),
    .locked(locked), .step_err(step_err), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .wrap(wrap), .wrap_cnt(wrap_cnt)
  );
  count_step_checker #(.ERR_W(2)) dut_b (
    .clk(clk), .rest(rest), .en(en), .q(q), .s(s), .clr(clr),
    .locked(locked_b), .step_err(step_err_b), .err_sticky(err_sticky_b),
    .err_cnt(err_cnt_b), .wrap(wrap_b), .wrap_cnt(wrap_cnt_b)
  );
  function automatic logic [21:0] obs();
    return {locked, step_err, err_sticky, wrap, err_cnt, wrap_cnt, err_cnt_b};
  endfunction
  function automatic logic [21:0] expv();
    return {m_mode == 2, m_serr, m_sticky, m_wrap, 8'(m_errc), 8'(m_wrapc), 2'(m_errc2)};
  endfunction
  task automatic model();
    int e;
    bit w, er;
    w = 0; er = 0;
    if (rest) begin
      m_mode = 0; m_prev = 0; m_run = 0;
      m_errc = 0; m_errc2 = 0; m_wrapc = 0; m_sticky = 0;
    end else begin
      if (en) begin
        if (m_mode == 0) begin
          m_mode = 1; m_run = 0;
        end else begin
          e = s ? (m_prev + 1) % 16 : (m_prev + 15) % 16;
          if (int'(q) == m_prev) begin
          end else if (int'(q) == e) begin
            w = s ? m_prev == 15 : m_prev == 0;
            if (m_mode == 1) begin
              m_run++;
              if (m_run == 4) m_mode = 2;
            end
          end else begin
            if (m_mode == 2) er = 1;
            m_mode = 1; m_run = 0;
          end
        end
        m_prev = int'(q);
      end
      if (clr) begin
        m_errc = 0; m_errc2 = 0; m_wrapc = 0; m_sticky = 0;
      end else begin
        if (er) begin
          m_errc = m_errc < 255 ? m_errc + 1 : 255;
          m_errc2 = m_errc2 < 3 ? m_errc2 + 1 : 3;
          m_sticky = 1;
        end
        if (w) m_wrapc = m_wrapc < 255 ? m_wrapc + 1 : 255;
      end
    end
    m_serr = er;
    m_wrap = w;
  endtask
  task automatic cyc(input logic r, input logic e, input logic sv, input logic c, input logic [3:0] qv);
    rest = r; en = e; s = sv; clr = c; q = qv;
    @(posedge clk);
    model();
    #1;
  endtask
  task automatic test_reset();
    cyc(1, 1, 1, 1, 4'd7);
    n_cmp++;
    if (obs() !== 22'd0) begin
      n_fail++; $display("FAIL reset: got %h want 0", obs());
    end
  endtask
  task automatic test_count_up();
    for (int i = 0; i < 18; i++) begin
      cyc(0, 1, 1, 0, 4'(i % 16));
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL count_up[%0d]: got %h want %h", i, obs(), expv());
      end
      n_cmp++;
      if (locked !== (i >= 4) || wrap !== (i == 16) || step_err !== 1'b0) begin
        n_fail++; $display("FAIL count_up_flags[%0d]: got l%b w%b e%b want l%b w%b e0", i, locked, wrap, step_err, i >= 4, i == 16);
      end
    end
    n_cmp++;
    if (wrap_cnt !== 8'd1 || err_cnt !== 8'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL count_up_end: got wc%0d ec%0d st%b want wc1 ec0 st0", wrap_cnt, err_cnt, err_sticky);
    end
  endtask
  task automatic test_error_relock();
    logic [3:0] seq [11] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 1, 0, seq[i]);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL error_relock[%0d]: got %h want %h", i, obs(), expv());
      end
      n_cmp++;
      if (step_err !== (i == 6) || locked !== (i < 6 || i == 10) || err_sticky !== (i >= 6)) begin
        n_fail++; $display("FAIL error_relock_flags[%0d]: got e%b l%b st%b", i, step_err, locked, err_sticky);
      end
    end
    n_cmp++;
    if (err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL error_relock_cnt: got %0d want 1", err_cnt);
    end
  endtask
  task automatic test_down_wrap();
    logic [3:0] seq [11] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE};
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 0, 0, seq[i]);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL down_wrap[%0d]: got %h want %h", i, obs(), expv());
      end
      if (i >= 4) begin
        n_cmp++;
        if (locked !== 1'b1 || wrap !== (i == 4) || step_err !== 1'b0) begin
          n_fail++; $display("FAIL down_wrap_flags[%0d]: got l%b w%b e%b want l1 w%b e0", i, locked, wrap, step_err, i == 4);
        end
      end
    end
  endtask
  task automatic test_saturate();
    cyc(0, 1, 1, 1, 4'(m_prev));
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 1, k == 5, 4'((m_prev + 5) % 16));
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL saturate[%0d]: got %h want %h", k, obs(), expv());
      end
      n_cmp++;
      if (k < 5 ? (err_cnt_b !== 2'(k < 2 ? k + 1 : 3) || err_sticky !== 1'b1) : (err_cnt_b !== 2'd0 || err_cnt !== 8'd0 || err_sticky !== 1'b0)) begin
        n_fail++; $display("FAIL saturate_cnt[%0d]: got ecb%0d ec%0d st%b", k, err_cnt_b, err_cnt, err_sticky);
      end
      if (k < 5)
        for (int j = 0; j < 4; j++) cyc(0, 1, 1, 0, 4'((m_prev + 1) % 16));
    end
  endtask
  task automatic test_enable();
    for (int j = 0; j < 4; j++) cyc(0, 1, 1, 0, 4'((m_prev + 1) % 16));
    for (int j = 0; j < 3; j++) begin
      cyc(0, 0, $urandom_range(1), 0, 4'($urandom_range(15)));
      n_cmp++;
      if (obs() !== expv() || locked !== 1'b1 || step_err !== 1'b0 || wrap !== 1'b0) begin
        n_fail++; $display("FAIL enable_off[%0d]: got %h want %h", j, obs(), expv());
      end
    end
    cyc(0, 1, 1, 0, 4'((m_prev + 1) % 16));
    n_cmp++;
    if (obs() !== expv() || locked !== 1'b1 || step_err !== 1'b0) begin
      n_fail++; $display("FAIL enable_resume: got %h want %h", obs(), expv());
    end
  endtask
  task automatic test_reset_mid();
    logic [3:0] seq [5] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
    cyc(0, 1, 1, 1, 4'(m_prev));
    for (int j = 0; j < 40 && m_wrapc < 2; j++) cyc(0, 1, 1, 0, 4'((m_prev + 1) % 16));
    n_cmp++;
    if (wrap_cnt !== 8'd2 || locked !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: got wc%0d l%b want wc2 l1", wrap_cnt, locked);
    end
    cyc(1, 1, 1, 0, 4'(m_prev));
    n_cmp++;
    if (obs() !== 22'd0) begin
      n_fail++; $display("FAIL reset_mid: got %h want 0", obs());
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, seq[i]);
      n_cmp++;
      if (obs() !== expv() || locked !== (i == 4)) begin
        n_fail++; $display("FAIL reset_mid_seq[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask
  task automatic test_random();
    int r;
    logic [3:0] qv;
    logic sv;
    for (int i = 0; i < 600; i++) begin
      sv = $urandom_range(1);
      r = $urandom_range(99);
      qv = r < 60 ? 4'(sv ? (m_prev + 1) % 16 : (m_prev + 15) % 16) : r < 80 ? 4'(m_prev) : 4'($urandom_range(15));
      cyc($urandom_range(99) < 2, $urandom_range(99) < 85, sv, $urandom_range(99) < 3, qv);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask
  initial begin
    rest = 1; en = 0; s = 0; clr = 0; q = 0;
    m_mode = 0; m_prev = 0; m_run = 0; m_errc = 0; m_errc2 = 0; m_wrapc = 0;
    m_serr = 0; m_wrap = 0; m_sticky = 0;
    test_reset();
    test_count_up();
    test_error_relock();
    test_down_wrap();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/count_step_checker.md
Name: count_step_checker

Overview:
Consumer stage placed directly downstream of the 4-bit up/down counter. Each enabled cycle it samples the counter value q and the direction s, and checks that every step is a legal +1/-1 (mod 2^WIDTH) or a hold. It tracks lock status, counts wrap-arounds, and flags, counts and latches step errors for debug and status readback.

Parameters:
WIDTH, 4, bit width of the monitored count value
LOCK_N, 4, consecutive good steps required to declare lock (legal range 1..15)
WRAP_W, 8, width of the saturating wrap counter
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, all logic on the rising edge
rest  in  1  reset, synchronous, active-high
en  in  1  sample enable; q and s are ignored when low
q  in  WIDTH  counter value under check
s  in  1  counter direction: 1 = up, 0 = down
clr  in  1  synchronous clear of err_cnt, wrap_cnt and err_sticky
locked  out  1  high while the FSM is in LOCKED
step_err  out  1  one-cycle pulse on an illegal step while locked
err_sticky  out  1  set by any step_err, cleared only by clr or rest
err_cnt  out  ERR_W  saturating count of step_err events
wrap  out  1  one-cycle pulse on a legal wrap step
wrap_cnt  out  WRAP_W  saturating count of wrap events

Behaviour:
- All outputs are registered. Response appears in the cycle after the sampling edge, so latency is 1.
- Reset: state = IDLE, prev = 0, run = 0. Every output is 0. rest overrides en and clr.
- en = 0: no sampling. State, prev and run hold. step_err = 0 and wrap = 0.
- Step classification on an enabled sample, using exp = s ? prev+1 : prev-1, both mod 2^WIDTH:
  - HOLD when q == prev.
  - GOOD when q == exp.
  - BAD otherwise.
  - prev <= q on every enabled sample.
- WRAP: a GOOD step with s = 1 from all-ones to 0, or with s = 0 from 0 to all-ones. Effects:
  - wrap pulses for one cycle.
  - wrap_cnt increments, saturating at 2^WRAP_W-1.
  - Applies in ACQ and LOCKED.
- FSM:
  - IDLE: first enabled sample captures prev and moves to ACQ with run = 0. No classification is made on this sample.
  - ACQ, GOOD: run++. When run reaches LOCK_N, go to LOCKED; locked rises the next cycle.
  - ACQ, BAD: run = 0, stay in ACQ. No step_err.
  - ACQ, HOLD: run unchanged.
  - LOCKED, GOOD or HOLD: stay in LOCKED.
  - LOCKED, BAD: step_err pulses. err_cnt increments (saturating at 2^ERR_W-1). err_sticky is set. Go to ACQ with run = 0; locked falls the next cycle.
- A direction change of s is legal: only exp changes, so a step that matches the new direction is GOOD.
- clr and an increment event in the same cycle: clr wins, so the affected counter or flag ends at 0.
- clr does not affect the FSM, prev, run or the pulse outputs.
- Reset asserted mid-operation returns the block to the full reset state on the next edge. The first sample after reset is the IDLE capture.
- Saturated counters hold their maximum value and never wrap.

Test Plan:
1. Reset, then en = 1, s = 1, q = 0,1,2,...,15,0,1:
   - locked = 1 one cycle after the q = 4 sample.
   - wrap pulses once after the 15 to 0 step; wrap_cnt = 1.
   - step_err, err_cnt and err_sticky stay 0.
2. While locked, q steps 6,7,B,C:
   - step_err pulses once after the B sample; err_cnt = 1, err_sticky = 1, locked = 0.
   - Relock after 4 further good steps (C,D,E,F gives locked after F).
   - err_sticky stays 1 throughout.
3. s = 0 with q = 3,2,1,0,F,E: wrap pulses once after the 0 to F step, and locked asserts. Repeating q = E for 5 cycles (holds) keeps locked = 1 with no errors.
4. Build with ERR_W = 2 and force 5 BAD steps, each from the locked state: err_cnt = 1,2,3,3,3 (saturates at 3). Then clr = 1 together with a 6th BAD step: err_cnt = 0 and err_sticky = 0.
5. en toggled low for 3 cycles mid-count while q keeps moving, then high with q = prev+1: the step is GOOD, and no outputs change while en = 0.
6. rest pulsed for 1 cycle while locked with wrap_cnt = 2: the next cycle shows all outputs 0. A following sequence 9,A,B,C,D is treated as a fresh capture, and locked rises after the D sample.
